// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver with a one-byte holding register.
// The line is resynchronised, sampled at mid-bit and delivered over a
// valid/ready handshake. Framing and overrun errors are sticky until cleared.
module uart_rx_buffered #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_rxd,
  output logic       io_out_valid,
  input  logic       io_out_ready,
  output logic [7:0] io_out_bits,
  output logic       io_frame_err,
  output logic       io_overrun,
  input  logic       io_clr_err,
  output logic       io_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_s;
  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [2:0]             idx_r;
  logic [7:0]             shift_r;
  logic                   valid_r;
  logic [7:0]             bits_r;
  logic                   frame_err_r;
  logic                   overrun_r;
  logic                   busy_r;

  logic                   at_zero_s;
  logic                   stop_sample_s;
  logic                   load_s;
  logic                   overrun_set_s;
  logic                   frame_set_s;

  // Synchroniser chain for the asynchronous pin; resets to the idle level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r <= '1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], io_rxd};
    end
  end

  assign rx_s = sync_r[SYNC_STAGES-1];

  // Stop-bit sample decode: deliver, drop as overrun, or flag framing error.
  always_comb begin
    at_zero_s     = 1'b0;
    stop_sample_s = 1'b0;
    load_s        = 1'b0;
    overrun_set_s = 1'b0;
    frame_set_s   = 1'b0;
    if (cnt_r == '0) begin
      at_zero_s = 1'b1;
    end else begin
      at_zero_s = 1'b0;
    end
    if ((state_r == ST_STOP) && at_zero_s) begin
      stop_sample_s = 1'b1;
      if (rx_s) begin
        if (!valid_r || io_out_ready) begin
          load_s = 1'b1;
        end else begin
          overrun_set_s = 1'b1;
        end
      end else begin
        frame_set_s = 1'b1;
      end
    end else begin
      stop_sample_s = 1'b0;
    end
  end

  // Receive FSM together with holding register, sticky flags and busy flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      idx_r       <= 3'd0;
      shift_r     <= 8'h00;
      valid_r     <= 1'b0;
      bits_r      <= 8'h00;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      // A new byte may land in the same cycle the old one is taken.
      if (load_s) begin
        valid_r <= 1'b1;
        bits_r  <= shift_r;
      end else if (valid_r && io_out_ready) begin
        valid_r <= 1'b0;
      end

      // Set has priority over clear on the sticky flags.
      if (frame_set_s) begin
        frame_err_r <= 1'b1;
      end else if (io_clr_err) begin
        frame_err_r <= 1'b0;
      end
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end else if (io_clr_err) begin
        overrun_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (!rx_s) begin
            state_r <= ST_START;
            cnt_r   <= CNT_HALF;
            busy_r  <= 1'b1;
          end
        end
        ST_START: begin
          if (at_zero_s) begin
            if (!rx_s) begin
              state_r <= ST_DATA;
              cnt_r   <= CNT_FULL;
              idx_r   <= 3'd0;
            end else begin
              // Start bit did not survive to mid-bit: a glitch.
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_DATA: begin
          if (at_zero_s) begin
            shift_r[idx_r] <= rx_s;
            cnt_r          <= CNT_FULL;
            if (idx_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_STOP: begin
          // Leaving at mid-stop lets a back-to-back start bit be caught.
          if (stop_sample_s) begin
            if (rx_s) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_BREAK;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_BREAK: begin
          // Hold here so a long low line is not decoded as 0x00 frames.
          if (rx_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign io_out_valid = valid_r;
  assign io_out_bits  = bits_r;
  assign io_frame_err = frame_err_r;
  assign io_overrun   = overrun_r;
  assign io_busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered at 16 clocks per bit, 2 sync stages.
module tb_uart_rx_buffered;

  localparam int CPB = 16;

  logic       clock;
  logic       reset;
  logic       io_rxd;
  logic       io_out_valid;
  logic       io_out_ready;
  logic [7:0] io_out_bits;
  logic       io_frame_err;
  logic       io_overrun;
  logic       io_clr_err;
  logic       io_busy;

  int n_vec;
  int n_err;
  int valid_cycles;
  int busy_run;
  int busy_max;
  logic [7:0] cap_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_bits;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[5];

  uart_rx_buffered #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_rxd       (io_rxd),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
    .io_frame_err (io_frame_err),
    .io_overrun   (io_overrun),
    .io_clr_err   (io_clr_err),
    .io_busy      (io_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observe outputs mid-cycle: valid occupancy, accepted bytes, busy runs.
  always @(negedge clock) begin
    if (io_out_valid) begin
      valid_cycles = valid_cycles + 1;
      if (io_out_ready) cap_q.push_back(io_out_bits);
    end
    if (io_busy) begin
      busy_run = busy_run + 1;
      if (busy_run > busy_max) busy_max = busy_run;
    end else begin
      busy_run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive one frame; leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    io_rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      io_rxd = d[i];
      wait_cyc(CPB);
    end
    io_rxd = stop;
    wait_cyc(CPB);
  endtask

  task automatic drain;
    io_out_ready = 1'b1;
    io_clr_err   = 1'b1;
    wait_cyc(1);
    io_out_ready = 1'b0;
    io_clr_err   = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    valid_cycles = 0;
    busy_run = 0;
    busy_max = 0;
    reset = 1'b1;
    io_rxd = 1'b1;
    io_out_ready = 1'b0;
    io_clr_err = 1'b0;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_bits: 8'hA5, exp_fe: 1'b0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_bits: 8'h00, exp_fe: 1'b0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_bits: 8'hFF, exp_fe: 1'b0};
    vecs[3] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b0, exp_bits: 8'h00, exp_fe: 1'b1};
    vecs[4] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_bits: 8'h81, exp_fe: 1'b0};

    // Reset state
    wait_cyc(4);
    check("reset_valid", {31'd0, io_out_valid}, 32'd0);
    check("reset_bits", {24'd0, io_out_bits}, 32'd0);
    check("reset_fe", {31'd0, io_frame_err}, 32'd0);
    check("reset_ov", {31'd0, io_overrun}, 32'd0);
    check("reset_busy", {31'd0, io_busy}, 32'd0);
    reset = 1'b0;
    wait_cyc(5);

    // Latency: valid low after edge 154, high after edge 155
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_cyc(154);
        check("lat_valid_154", {31'd0, io_out_valid}, 32'd0);
        wait_cyc(1);
        check("lat_valid_155", {31'd0, io_out_valid}, 32'd1);
        check("lat_bits", {24'd0, io_out_bits}, 32'hA5);
        check("lat_fe", {31'd0, io_frame_err}, 32'd0);
      end
    join
    io_rxd = 1'b1;
    io_out_ready = 1'b1;
    wait_cyc(1);
    io_out_ready = 1'b0;
    check("lat_valid_clear", {31'd0, io_out_valid}, 32'd0);
    wait_cyc(3);
    check("ready_no_effect", {31'd0, io_out_valid}, 32'd0);
    wait_cyc(10);

    // Table-driven single frames
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].data, vecs[v].stop);
      io_rxd = 1'b1;
      wait_cyc(20);
      check("tbl_valid", {31'd0, io_out_valid}, {31'd0, vecs[v].exp_valid});
      if (vecs[v].exp_valid) check("tbl_bits", {24'd0, io_out_bits}, {24'd0, vecs[v].exp_bits});
      check("tbl_fe", {31'd0, io_frame_err}, {31'd0, vecs[v].exp_fe});
      check("tbl_ov", {31'd0, io_overrun}, 32'd0);
      check("tbl_busy", {31'd0, io_busy}, 32'd0);
      drain();
      check("tbl_drained", {30'd0, io_out_valid, io_frame_err}, 32'd0);
      wait_cyc(5);
    end

    // Back-to-back frames with ready held high
    io_out_ready = 1'b1;
    valid_cycles = 0;
    cap_q.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    wait_cyc(20);
    io_out_ready = 1'b0;
    check("b2b_count", cap_q.size(), 32'd3);
    if (cap_q.size() == 3) begin
      check("b2b_0", {24'd0, cap_q[0]}, 32'h00);
      check("b2b_1", {24'd0, cap_q[1]}, 32'hFF);
      check("b2b_2", {24'd0, cap_q[2]}, 32'h55);
    end
    check("b2b_valid_cycles", valid_cycles, 32'd3);
    check("b2b_ov", {31'd0, io_overrun}, 32'd0);

    // Overrun: second byte dropped, first kept
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    wait_cyc(20);
    check("ovr_valid", {31'd0, io_out_valid}, 32'd1);
    check("ovr_bits", {24'd0, io_out_bits}, 32'h12);
    check("ovr_ov", {31'd0, io_overrun}, 32'd1);
    check("ovr_fe", {31'd0, io_frame_err}, 32'd0);
    io_clr_err = 1'b1;
    wait_cyc(1);
    io_clr_err = 1'b0;
    check("ovr_cleared", {31'd0, io_overrun}, 32'd0);
    check("ovr_valid_kept", {31'd0, io_out_valid}, 32'd1);
    check("ovr_bits_kept", {24'd0, io_out_bits}, 32'h12);
    drain();

    // Framing error followed by a 50-bit break
    send_frame(8'h3C, 1'b0);
    wait_cyc(50 * CPB);
    check("brk_fe", {31'd0, io_frame_err}, 32'd1);
    check("brk_valid", {31'd0, io_out_valid}, 32'd0);
    check("brk_busy", {31'd0, io_busy}, 32'd1);
    io_rxd = 1'b1;
    wait_cyc(10);
    check("brk_busy_released", {31'd0, io_busy}, 32'd0);
    send_frame(8'h7E, 1'b1);
    wait_cyc(20);
    check("brk_next_valid", {31'd0, io_out_valid}, 32'd1);
    check("brk_next_bits", {24'd0, io_out_bits}, 32'h7E);
    drain();
    wait_cyc(5);

    // Glitch of 5 clocks on the line
    busy_max = 0;
    valid_cycles = 0;
    io_rxd = 1'b0;
    wait_cyc(5);
    io_rxd = 1'b1;
    wait_cyc(30);
    check("glitch_valid", valid_cycles, 32'd0);
    check("glitch_flags", {30'd0, io_frame_err, io_overrun}, 32'd0);
    check("glitch_busy_idle", {31'd0, io_busy}, 32'd0);
    check("glitch_busy_seen", {31'd0, (busy_max >= 1 && busy_max <= 10)}, 32'd1);

    // Reset during bit 4, then a clean frame
    io_rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      io_rxd = 1'b0;
      wait_cyc(CPB);
    end
    wait_cyc(CPB / 2);
    check("rst_mid_busy", {31'd0, io_busy}, 32'd1);
    reset = 1'b1;
    io_rxd = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(1);
    check("rst_mid_idle", {31'd0, io_busy}, 32'd0);
    wait_cyc(40);
    check("rst_mid_no_valid", {31'd0, io_out_valid}, 32'd0);
    send_frame(8'h81, 1'b1);
    wait_cyc(20);
    check("rst_after_valid", {31'd0, io_out_valid}, 32'd1);
    check("rst_after_bits", {24'd0, io_out_bits}, 32'h81);
    check("rst_after_flags", {30'd0, io_frame_err, io_overrun}, 32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
